// File: rtl/ar_mem_reader_pkg.sv
// rtl/ar_mem_reader_pkg.sv - shared state type and widths for the AR read path
package ar_mem_reader_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;
   localparam int LEN_W      = 4;
   localparam int LAT_W      = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } rd_state_e;

endpackage

// File: rtl/ar_mem_reader_if.sv
// rtl/ar_mem_reader_if.sv - request, memory port and data-register signals of the reader
interface ar_mem_reader_if
   import ar_mem_reader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              rd_req;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  rd_len;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              busy;

   modport slave (
      input  rd_req, addr, rd_len, mem_rdata,
      output mem_en, mem_addr, rd_data, rd_valid, rd_last, busy
   );

   modport master (
      output rd_req, addr, rd_len, mem_rdata,
      input  mem_en, mem_addr, rd_data, rd_valid, rd_last, busy
   );

endinterface

// File: rtl/ar_mem_reader_mem_rd_lat_cnt.sv
// rtl/ar_mem_reader_mem_rd_lat_cnt.sv - loadable down-counter timing the memory read latency
module mem_rd_lat_cnt
   import ar_mem_reader_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [LAT_W-1:0] load_val,
   output logic             zero
);

   logic [LAT_W-1:0] cnt_q;
   logic [LAT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - LAT_W'(1);
      end
   end

   // Flag reflects the post-decrement value so WAIT leaves in the cycle the count expires.
   assign zero = (cnt_d == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ar_mem_reader.sv
// rtl/ar_mem_reader.sv - fetches a burst of words at the AR address and strobes each into the data register
module ar_mem_reader
   import ar_mem_reader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input logic            clk,
   input logic            rst,
   ar_mem_reader_if.slave bus
);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;
   logic              busy_q, busy_d;
   logic              lat_load, lat_dec, lat_zero;

   mem_rd_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (lat_load),
      .dec      (lat_dec),
      .load_val (LAT_LOAD),
      .zero     (lat_zero)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      mem_en_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      lat_load   = 1'b0;
      lat_dec    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.rd_req) begin
               addr_d     = bus.addr;
               cnt_d      = bus.rd_len;
               mem_en_d   = 1'b1;
               mem_addr_d = bus.addr;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            lat_load = 1'b1;
            state_d  = (RD_LAT > 1) ? WAIT : CAPTURE;
         end
         WAIT: begin
            lat_dec = 1'b1;
            if (lat_zero) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            rd_data_d  = bus.mem_rdata;
            rd_valid_d = 1'b1;
            rd_last_d  = (cnt_q == '0);
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               // Next word is issued in the same cycle the current one is strobed out.
               cnt_d      = cnt_q - LEN_W'(1);
               addr_d     = addr_q + ADDR_W'(1);
               mem_en_d   = 1'b1;
               mem_addr_d = addr_d;
               state_d    = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.mem_en   = mem_en_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_last  = rd_last_q;
   assign bus.busy     = busy_q;

endmodule
